// File: rtl/audio_echo_fx.sv
// Stereo feedback-echo between codec ADC and DAC streams.
// Each channel mixes its input with gain/8 of its own output from `delay` samples earlier.

module audio_echo_fx_lane #(
    parameter int DATA_W  = 16,
    parameter int DELAY_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic [DELAY_W-1:0] delay,
    input  logic [2:0]         gain,
    input  logic               bypass
);
    localparam int                DEPTH = 1 << DELAY_W;
    localparam int                EXT_W = DATA_W + 4;
    localparam logic [DELAY_W:0]  FULL  = {1'b1, {DELAY_W{1'b0}}};
    localparam logic [DATA_W-1:0] SMAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SMIN  = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, READ, MIX, OUT} state_t;
    state_t state, state_nxt;

    logic [DATA_W-1:0]  x_q;
    logic [DELAY_W:0]   eff_delay;
    logic [DELAY_W-1:0] wr_ptr;
    logic [DELAY_W:0]   fill;
    logic [DELAY_W-1:0] rd_addr;
    logic [DATA_W-1:0]  rd_data;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic               accept, commit, advance;

    logic                    d_live, no_ovf;
    logic signed [EXT_W-1:0] d_ext, g_ext, x_ext, prod, sum;
    logic [DATA_W-1:0]       y;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: if (in_valid) begin
                accept    = 1'b1;
                state_nxt = READ;
            end
            READ: state_nxt = MIX;
            MIX: begin
                commit    = 1'b1;
                state_nxt = OUT;
            end
            OUT: if (out_ready) begin
                advance   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE) & ~reset;
    assign out_valid = (state == OUT);

    // Full-depth delay has low bits zero, so it reads the slot about to be overwritten.
    assign rd_addr = wr_ptr - eff_delay[DELAY_W-1:0];

    // RAM is never cleared; slots not yet written since reset are masked by fill.
    assign d_live = (fill >= eff_delay);
    assign d_ext  = d_live ? {{4{rd_data[DATA_W-1]}}, rd_data} : '0;
    assign g_ext  = {{(DATA_W+1){1'b0}}, gain};
    assign x_ext  = {{4{x_q[DATA_W-1]}}, x_q};
    assign prod   = d_ext * g_ext;
    assign sum    = x_ext + (prod >>> 3);
    assign no_ovf = (&sum[EXT_W-1:DATA_W-1]) | ~(|sum[EXT_W-1:DATA_W-1]);
    assign y      = bypass ? x_q :
                    no_ovf ? sum[DATA_W-1:0] :
                    (sum[EXT_W-1] ? SMIN : SMAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q       <= '0;
            eff_delay <= '0;
            wr_ptr    <= '0;
            fill      <= '0;
            out_data  <= '0;
        end else begin
            if (accept) begin
                x_q       <= in_data;
                eff_delay <= (delay == '0) ? FULL : {1'b0, delay};
            end
            if (commit) out_data <= y;
            if (advance) begin
                wr_ptr <= wr_ptr + DELAY_W'(1);
                if (fill != FULL) fill <= fill + (DELAY_W+1)'(1);
            end
        end
    end

    // Read in READ and write in MIX land in different cycles, so no RDW hazard.
    always_ff @(posedge clk) begin
        if (commit) mem[wr_ptr] <= y;
        rd_data <= mem[rd_addr];
    end
endmodule

module audio_echo_fx #(
    parameter int DATA_W  = 16,
    parameter int DELAY_W = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0][DATA_W-1:0] in_data,
    input  logic [1:0]             in_valid,
    output logic [1:0]             in_ready,
    output logic [1:0][DATA_W-1:0] out_data,
    output logic [1:0]             out_valid,
    input  logic [1:0]             out_ready,
    input  logic [DELAY_W-1:0]     delay,
    input  logic [2:0]             gain,
    input  logic                   bypass
);
    for (genvar ch = 0; ch < 2; ch++) begin : g_lane
        audio_echo_fx_lane #(
            .DATA_W (DATA_W),
            .DELAY_W(DELAY_W)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .in_data  (in_data[ch]),
            .in_valid (in_valid[ch]),
            .in_ready (in_ready[ch]),
            .out_data (out_data[ch]),
            .out_valid(out_valid[ch]),
            .out_ready(out_ready[ch]),
            .delay    (delay),
            .gain     (gain),
            .bypass   (bypass)
        );
    end
endmodule

// File: tb/tb_audio_echo_fx.sv
// Bench for audio_echo_fx: directed vector table, stall/reset sequences, random traffic vs model.

module tb_audio_echo_fx;
    localparam int DATA_W  = 16;
    localparam int DELAY_W = 4;
    localparam int NS      = 30;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [1:0][DATA_W-1:0] in_data = '0;
    logic [1:0]             in_valid = '0;
    logic [1:0]             in_ready;
    logic [1:0][DATA_W-1:0] out_data;
    logic [1:0]             out_valid;
    logic [1:0]             out_ready = '0;
    logic [DELAY_W-1:0]     delay = '0;
    logic [2:0]             gain = '0;
    logic                   bypass = 1'b0;

    audio_echo_fx #(.DATA_W(DATA_W), .DELAY_W(DELAY_W)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .delay(delay), .gain(gain), .bypass(bypass)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failures = 0;

    function automatic void check(string name, int act, int exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Reference: y[n] = sat(x[n] + floor(y[n-D]*g/8)), y[k<0] = 0; bypass gives y[n] = x[n].
    int hist [2][512];
    int n [2];

    function automatic int model(int c, int x, int dly, int g, bit byp);
        int d_eff, p, s, y;
        d_eff = (dly == 0) ? (1 << DELAY_W) : dly;
        s = 0;
        if (n[c] >= d_eff) begin
            p = hist[c][n[c] - d_eff] * g;
            s = (p < 0 && (p % 8) != 0) ? (p / 8 - 1) : (p / 8);
        end
        y = x + s;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        if (byp) y = x;
        hist[c][n[c]] = y;
        n[c]++;
        return y;
    endfunction

    function automatic int sval(int c);
        logic [DATA_W-1:0] v;
        v = out_data[c];
        return int'($signed(v));
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = '0;
        out_ready = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n[0] = 0;
        n[1] = 0;
    endtask

    // One full transaction on channel c; hold = cycles out_ready stays low after out_valid.
    task automatic run_one(input int c, input int x, input int dly, input int g, input bit byp,
                           input int hold, output int y, output int lat);
        int k;
        logic [DATA_W-1:0] held;
        delay  = dly[DELAY_W-1:0];
        gain   = g[2:0];
        bypass = byp;
        @(negedge clk);
        in_data[c]  = x[DATA_W-1:0];
        in_valid[c] = 1'b1;
        k = 0;
        while (!in_ready[c] && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) check("accept_timeout", k, 0);
        @(posedge clk);
        #1 in_valid[c] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid[c] && lat < 20);
        y = sval(c);
        held = out_data[c];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_data", int'(out_data[c]), int'(held));
            check("hold_in_ready", int'(in_ready[c]), 0);
            check("hold_out_valid", int'(out_valid[c]), 1);
        end
        @(negedge clk);
        out_ready[c] = 1'b1;
        @(posedge clk);
        #1 out_ready[c] = 1'b0;
    endtask

    typedef struct {
        bit    rst;
        int    ch;
        int    x;
        int    dly;
        int    g;
        bit    byp;
        int    exp;
        string name;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit rst, int ch, int x, int dly, int g, bit byp, int exp, string name);
        vec_t v;
        v.rst = rst; v.ch = ch; v.x = x; v.dly = dly; v.g = g; v.byp = byp; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endfunction

    // Random-phase per-channel bookkeeping
    logic [1:0] busy, seen, acc;
    int lat_r [2];
    int hold_r [2];
    int gap_r [2];
    int sent [2];
    int exp_r [2];
    int xq [2];

    initial begin
        int y, lat, x, cyc;
        bit abort;
        logic [DATA_W-1:0] r;
        logic [DATA_W-1:0] held;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_data0", int'(out_data[0]), 0);
        check("rst_out_data1", int'(out_data[1]), 0);
        reset = 1'b0;
        n[0] = 0; n[1] = 0;
        @(negedge clk);
        check("post_rst_in_ready", int'(in_ready), 3);

        add(1, 0, 1000, 4, 0, 0, 1000, "basic");
        add(1, 0, 16000, 2, 4, 0, 16000, "imp0");
        add(0, 0, 0, 2, 4, 0, 0, "imp1");
        add(0, 0, 0, 2, 4, 0, 8000, "imp2");
        add(0, 0, 0, 2, 4, 0, 0, "imp3");
        add(0, 0, 0, 2, 4, 0, 4000, "imp4");
        add(0, 0, 0, 2, 4, 0, 0, "imp5");
        add(0, 0, 0, 2, 4, 0, 2000, "imp6");
        add(1, 1, 30000, 1, 7, 0, 30000, "satp0");
        add(0, 1, 30000, 1, 7, 0, 32767, "satp1");
        add(1, 1, -30000, 1, 7, 0, -30000, "satn0");
        add(0, 1, -30000, 1, 7, 0, -32768, "satn1");
        add(1, 0, -5, 1, 3, 0, -5, "floor0");
        add(0, 0, 0, 1, 3, 0, -2, "floor1");
        add(1, 1, 5000, 1, 7, 0, 5000, "byp0");
        add(0, 1, 5000, 1, 7, 1, 5000, "byp1");
        add(0, 1, 0, 1, 7, 0, 4375, "byp2");
        add(1, 0, 1000, 0, 4, 0, 1000, "d0_imp");
        for (int i = 1; i < 16; i++) add(0, 0, 0, 0, 4, 0, 0, "d0_zero");
        add(0, 0, 0, 0, 4, 0, 500, "d0_echo");

        foreach (tbl[i]) begin
            if (tbl[i].rst) apply_reset();
            run_one(tbl[i].ch, tbl[i].x, tbl[i].dly, tbl[i].g, tbl[i].byp, 0, y, lat);
            check({tbl[i].name, "_data"}, y, tbl[i].exp);
            check({tbl[i].name, "_lat"}, lat, 3);
        end

        // Backpressure: second sample waits with in_valid high while output is stalled
        apply_reset();
        delay = 4'd4; gain = 3'd0; bypass = 1'b0;
        @(negedge clk);
        in_data[0] = 16'd111;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1 in_data[0] = 16'd222;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid[0] && lat < 20);
        check("bp_lat", lat, 3);
        held = out_data[0];
        check("bp_first", int'(held), 111);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_stable", int'(out_data[0]), 111);
            check("bp_in_ready", int'(in_ready[0]), 0);
            check("bp_out_valid", int'(out_valid[0]), 1);
        end
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1 out_ready[0] = 1'b0;
        @(negedge clk);
        check("bp_idle_ready", int'(in_ready[0]), 1);
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid[0] && lat < 20);
        check("bp_second_lat", lat, 3);
        check("bp_second", sval(0), 222);
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1 out_ready[0] = 1'b0;

        // Random concurrent traffic on both channels
        apply_reset();
        busy = '0; seen = '0; acc = '0;
        abort = 1'b0;
        for (int c = 0; c < 2; c++) begin
            lat_r[c] = 0; hold_r[c] = 0; gap_r[c] = 0;
        end
        for (int blk = 0; blk < 6 && !abort; blk++) begin
            @(negedge clk);
            delay  = (blk == 0) ? 4'd1 : 4'($urandom_range(0, 15));
            gain   = (blk == 0) ? 3'd7 : 3'($urandom_range(0, 7));
            bypass = (blk == 4);
            sent[0] = 0; sent[1] = 0;
            cyc = 0;
            while (!abort && (sent[0] < NS || sent[1] < NS || busy != 0 || in_valid != 0 || acc != 0)) begin
                @(negedge clk);
                cyc++;
                if (cyc > 5000) begin
                    check("rand_block_timeout", cyc, 0);
                    abort = 1'b1;
                end
                for (int c = 0; c < 2; c++) begin
                    if (out_ready[c]) begin
                        out_ready[c] = 1'b0;
                        busy[c] = 1'b0;
                        seen[c] = 1'b0;
                        gap_r[c] = $urandom_range(0, 2);
                        check("rand_valid_drop", int'(out_valid[c]), 0);
                    end
                    if (acc[c]) begin
                        acc[c] = 1'b0;
                        in_valid[c] = 1'b0;
                        busy[c] = 1'b1;
                        lat_r[c] = 0;
                        hold_r[c] = $urandom_range(0, 3);
                    end
                    if (busy[c]) begin
                        lat_r[c]++;
                        if (out_valid[c]) begin
                            if (!seen[c]) begin
                                seen[c] = 1'b1;
                                check("rand_lat", lat_r[c], 3);
                            end
                            check("rand_data", sval(c), exp_r[c]);
                            if (hold_r[c] > 0) hold_r[c]--;
                            else out_ready[c] = 1'b1;
                        end else if (lat_r[c] > 12) begin
                            check("rand_out_timeout", lat_r[c], 3);
                            abort = 1'b1;
                        end
                    end else if (!in_valid[c]) begin
                        if (gap_r[c] > 0) gap_r[c]--;
                        else if (sent[c] < NS) begin
                            r = 16'($urandom);
                            x = int'($signed(r));
                            xq[c] = x;
                            in_data[c] = r;
                            in_valid[c] = 1'b1;
                            sent[c]++;
                        end
                    end
                    if (in_valid[c] && in_ready[c]) begin
                        acc[c] = 1'b1;
                        exp_r[c] = model(c, xq[c], int'(delay), int'(gain), bypass);
                    end
                end
            end
        end

        // Reset while in OUT, then confirm stale RAM never leaks into the echo
        apply_reset();
        delay = 4'd3; gain = 3'd7; bypass = 1'b0;
        @(negedge clk);
        in_data[1] = 16'd1234;
        in_valid[1] = 1'b1;
        @(posedge clk);
        #1 in_valid[1] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid[1] && lat < 20);
        check("rst_mid_reach_out", int'(out_valid[1]), 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_valid", int'(out_valid[1]), 0);
        check("rst_mid_ready", int'(in_ready[1]), 0);
        check("rst_mid_data", int'(out_data[1]), 0);
        @(negedge clk);
        reset = 1'b0;
        run_one(1, 100, 3, 7, 0, 0, y, lat);
        check("stale0", y, 100);
        run_one(1, 0, 3, 7, 0, 0, y, lat);
        check("stale1", y, 0);
        run_one(1, 0, 3, 7, 0, 0, y, lat);
        check("stale2", y, 0);
        run_one(1, 0, 3, 7, 0, 0, y, lat);
        check("stale3_echo", y, 87);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule

// File: doc/audio_echo_fx.md
# audio_echo_fx

Stereo feedback-echo stage that sits between the audio codec's ADC stream outputs and DAC stream inputs. It replaces the plain ADC-to-DAC tie-back. Each channel accepts one sample per Avalon-ST handshake and mixes it with a scaled copy of its own output from `delay` samples earlier, using a per-channel circular buffer in block RAM. The result is saturated to the sample width and presented to the DAC sink.

## Interface
Parameters:
- `DATA_W`, 16: signed two's-complement sample width.
- `DELAY_W`, 10: buffer address width; depth is 2^DELAY_W samples per channel.

Ports:
- `clk` in 1: system clock (CLOCK_50 domain).
- `reset` in 1: asynchronous, active-high reset.
- `in_data` in 2×DATA_W: ADC samples, [0]=left, [1]=right.
- `in_valid` in 2: per-channel ADC valid.
- `in_ready` out 2: per-channel ready back to the ADC source.
- `out_data` out 2×DATA_W: processed samples to the DAC.
- `out_valid` out 2: per-channel valid to the DAC sink.
- `out_ready` in 2: per-channel DAC ready.
- `delay` in DELAY_W: echo delay in samples; 0 means 2^DELAY_W.
- `gain` in 3: feedback gain of gain/8, range 0..7/8.
- `bypass` in 1: when 1, out = in, but the buffer is still written.

## Operation
- The two channels are fully independent. Each has its own FSM, buffer, write pointer `wr_ptr` and fill counter `fill`.
- FSM states and transitions:
  - IDLE: `in_ready`=1. On `in_valid`: latch x, latch eff_delay (`delay`==0 → 2^DELAY_W), then go to READ.
  - READ: present read address `wr_ptr − eff_delay`, computed mod 2^DELAY_W.
  - MIX: RAM data d is valid this cycle.
    - If `fill` < eff_delay, d is treated as 0, because the location has not been written since reset.
    - s = (d × gain) >>> 3, arithmetic shift, truncation toward −inf.
    - y = sat(x + s), computed at DATA_W+1 bits and clamped to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
    - If `bypass`, y = x.
    - Register y into `out_data`, write y to mem[`wr_ptr`], then go to OUT.
  - OUT: `out_valid`=1 and `out_data` held stable. On `out_ready`: `wr_ptr`++ (wraps at 2^DELAY_W), `fill`++ (saturates at 2^DELAY_W), then go to IDLE.
- `delay`, `gain` and `bypass` are sampled as follows: `delay` at acceptance; `gain` and `bypass` in MIX. Changing them mid-sample affects only later samples.
- `in_ready` = (state==IDLE) & ~`reset`.
- RAM contents are not reset. Correct output after reset relies only on the `fill` gating.

## Timing
- Reset values: state IDLE, `out_valid`=0, `out_data`=0, `wr_ptr`=0, `fill`=0, `in_ready`=0 while `reset` is high.
- Latency: the input handshake at cycle T gives `out_valid`=1 at T+3.
- Throughput: at most 1 sample per 4 cycles per channel, far above the 48 kHz rate.
- `out_valid` stays high, and `out_data` stays unchanged, until `out_ready` is sampled high. There is no timeout.
- `in_ready` is 0 from acceptance until the cycle after the output handshake. No input is dropped while busy; the source is simply stalled.
- Simultaneous handshakes on both channels are handled independently in the same cycle.
- Reset asserted mid-sample: the in-flight sample is discarded, `out_valid` drops asynchronously, and the FSM returns to IDLE.
- With `delay`=1 the read address is the location written by the previous sample, which is already committed. No RAM read-during-write hazard exists, because the read and the write occur in different states.
- Pointer wrap: at `wr_ptr`=2^DELAY_W−1 with `delay`=2, the read address is 2^DELAY_W−3.

## Test plan
- Reset, then `gain`=0, `delay`=4, left input 1000 → left `out_data`=1000, with `out_valid` rising 3 cycles after `in_valid`∧`in_ready`.
- `gain`=4, `delay`=2, impulse 16000 followed by zeros, `out_ready`=1 → outputs 16000, 0, 8000, 0, 4000, 0, 2000.
- Saturation: `gain`=7, `delay`=1, inputs 30000, 30000 → 30000, then 32767. Repeat with negative inputs → −32768.
- Backpressure: hold `out_ready`=0 for 20 cycles → `out_data` is stable, `in_ready` stays 0, and no second sample is accepted. Release → next sample accepted the cycle after IDLE.
- `delay`=0 with DELAY_W=4: impulse then zeros, `gain`=4 → outputs are 0 until sample index 16, which equals half the impulse.
- Reset asserted while in OUT: `out_valid` goes to 0 immediately. After release, `delay`=3, `gain`=7, input 100 → output 100, with no echo from stale RAM because of the `fill` gating.
